// File: rtl/verify_gate_pkg.sv
// Shared types for the verify-and-gate stage: output FSM states and the
// default-width buffered beat layout.
package verify_gate_pkg;

  localparam int PKG_DATA_WIDTH = 512;
  localparam int PKG_ID_WIDTH   = 6;
  localparam int PKG_KEEP_WIDTH = PKG_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } gate_state_t;

  typedef struct packed {
    logic                      last;
    logic [PKG_ID_WIDTH-1:0]   id;
    logic [PKG_KEEP_WIDTH-1:0] keep;
    logic [PKG_DATA_WIDTH-1:0] data;
  } beat_t;

endpackage

// File: rtl/verify_gate_ram.sv
// Simple dual-port beat buffer: synchronous write, asynchronous read.
module verify_gate_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents need no reset since occupancy is tracked outside.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/verify_gate_buf.sv
// Verify-and-gate stage: buffers host beats, mirrors them to a verifier and
// releases or discards each packet according to its in-order verdict.
// Optional packet counters: define VERIFY_GATE_STATS_EN.
module verify_gate_buf
  import verify_gate_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 6,
  parameter int DEPTH      = 64
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic                    s_axis_tlast,
  output logic                    chk_axis_tvalid,
  input  logic                    chk_axis_tready,
  output logic [DATA_WIDTH-1:0]   chk_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] chk_axis_tkeep,
  output logic [ID_WIDTH-1:0]     chk_axis_tid,
  output logic                    chk_axis_tlast,
  input  logic                    verdict_valid,
  output logic                    verdict_ready,
  input  logic                    verdict_data,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic                    m_axis_tlast,
  output logic [31:0]             pass_cnt,
  output logic [31:0]             drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = DATA_WIDTH / 8;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [KW-1:0]         keep;
    logic [DATA_WIDTH-1:0] data;
  } beat_w_t;

  localparam int BW = $bits(beat_w_t);

  gate_state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;
  beat_w_t       wr_beat, head;
  logic [BW-1:0] head_raw;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Input side: ready and mirror-valid share the same gating so a beat
  // transfers to buffer and verifier together or not at all.
  assign s_axis_tready   = !full && chk_axis_tready && !areset;
  assign chk_axis_tvalid = s_axis_tvalid && !full && !areset;
  assign chk_axis_tdata  = s_axis_tdata;
  assign chk_axis_tkeep  = s_axis_tkeep;
  assign chk_axis_tid    = s_axis_tid;
  assign chk_axis_tlast  = s_axis_tlast;
  assign push            = s_axis_tvalid && s_axis_tready;

  assign wr_beat = '{last: s_axis_tlast, id: s_axis_tid, keep: s_axis_tkeep, data: s_axis_tdata};

  verify_gate_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BW)
  ) u_ram (
    .clk   (aclk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_beat),
    .raddr (rd_ptr_q),
    .rdata (head_raw)
  );

  assign head         = beat_w_t'(head_raw);
  assign m_axis_tdata = head.data;
  assign m_axis_tkeep = head.keep;
  assign m_axis_tid   = head.id;
  assign m_axis_tlast = head.last;

  // Output FSM: wait for a verdict, then release or discard one packet.
  always_comb begin
    state_d       = state_q;
    verdict_ready = 1'b0;
    m_axis_tvalid = 1'b0;
    pop           = 1'b0;
    unique case (state_q)
      IDLE: begin
        verdict_ready = !empty;
        if (verdict_valid && !empty) state_d = verdict_data ? PASS : DROP;
      end
      PASS: begin
        m_axis_tvalid = !empty;
        if (!empty && m_axis_tready) begin
          pop = 1'b1;
          if (head.last) state_d = IDLE;
        end
      end
      DROP: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  // State, pointer and occupancy registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef VERIFY_GATE_STATS_EN
  logic [31:0] pass_cnt_q, pass_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Count each packet once, when its last beat leaves the buffer.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pop && head.last && state_q == PASS) pass_cnt_d = pass_cnt_q + 32'd1;
    if (pop && head.last && state_q == DROP) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign pass_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_verify_gate_buf.sv
// Directed bench for verify_gate_buf (DEPTH=4, 64-bit data).
module tb_verify_gate_buf;

  logic        aclk;
  logic        areset;
  logic        s_axis_tvalid, s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic [5:0]  s_axis_tid;
  logic        s_axis_tlast;
  logic        chk_axis_tvalid, chk_axis_tready;
  logic [63:0] chk_axis_tdata;
  logic [7:0]  chk_axis_tkeep;
  logic [5:0]  chk_axis_tid;
  logic        chk_axis_tlast;
  logic        verdict_valid, verdict_ready, verdict_data;
  logic        m_axis_tvalid, m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic [5:0]  m_axis_tid;
  logic        m_axis_tlast;
  logic [31:0] pass_cnt, drop_cnt;

  verify_gate_buf #(
    .DATA_WIDTH (64),
    .ID_WIDTH   (6),
    .DEPTH      (4)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tid      (s_axis_tid),
    .s_axis_tlast    (s_axis_tlast),
    .chk_axis_tvalid (chk_axis_tvalid),
    .chk_axis_tready (chk_axis_tready),
    .chk_axis_tdata  (chk_axis_tdata),
    .chk_axis_tkeep  (chk_axis_tkeep),
    .chk_axis_tid    (chk_axis_tid),
    .chk_axis_tlast  (chk_axis_tlast),
    .verdict_valid   (verdict_valid),
    .verdict_ready   (verdict_ready),
    .verdict_data    (verdict_data),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tid      (m_axis_tid),
    .m_axis_tlast    (m_axis_tlast),
    .pass_cnt        (pass_cnt),
    .drop_cnt        (drop_cnt)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int n_chk = 0;
  int n_bad = 0;
  int exp_pass = 0;
  int exp_drop = 0;
  logic chk_toggle = 1'b0;

  logic [95:0] rx_q [$];
  logic [95:0] exp_q [$];
  int mv_cnt = 0;
  int vh_cnt = 0;

  // Observe handshakes at the falling edge; inputs only change just after
  // the rising edge, so these values hold at the next rising edge.
  always @(negedge aclk) begin
    if (!areset) begin
      if (m_axis_tvalid && m_axis_tready)
        rx_q.push_back({17'd0, m_axis_tlast, m_axis_tid, m_axis_tkeep, m_axis_tdata});
      if (m_axis_tvalid) mv_cnt++;
      if (verdict_valid && verdict_ready) vh_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                           input logic [5:0] id, input logic l);
    logic ok;
    ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tid    = id;
    s_axis_tlast  = l;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (chk_toggle) chk_axis_tready = ~chk_axis_tready;
      #2;
      ok = s_axis_tready;
      if (ok)
        check_val("mirror", {17'd0, chk_axis_tlast, chk_axis_tid, chk_axis_tkeep, chk_axis_tdata},
                  {17'd0, l, id, k, d});
      tick();
    end
    s_axis_tvalid = 1'b0;
    if (!ok) check_val("s_hs_timeout", 96'd0, 96'd1);
  endtask

  task automatic send_pkt(input int n, input logic [5:0] id, input logic [63:0] base,
                          input logic [7:0] lastkeep, input int n_exp);
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    for (int i = 0; i < n; i++) begin
      d = base + 64'(i);
      l = (i == n - 1);
      k = l ? lastkeep : 8'hFF;
      if (i < n_exp) exp_q.push_back({17'd0, l, id, k, d});
      send_beat(d, k, id, l);
    end
  endtask

  task automatic give_verdict(input logic v);
    logic ok;
    ok = 1'b0;
    verdict_valid = 1'b1;
    verdict_data  = v;
    for (int i = 0; i < 40 && !ok; i++) begin
      #2;
      ok = verdict_ready;
      tick();
    end
    verdict_valid = 1'b0;
    if (!ok) check_val("verdict_timeout", 96'd0, 96'd1);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 60 && rx_q.size() < n; i++) tick();
  endtask

  task automatic compare_rx(input string tag);
    check_val({tag, "_len"}, 96'(rx_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check_val({tag, "_beat"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_counters(input string tag);
`ifdef VERIFY_GATE_STATS_EN
    check_val({tag, "_pass_cnt"}, 96'(pass_cnt), 96'(exp_pass));
    check_val({tag, "_drop_cnt"}, 96'(drop_cnt), 96'(exp_drop));
`else
    check_val({tag, "_pass_cnt"}, 96'(pass_cnt), 96'd0);
    check_val({tag, "_drop_cnt"}, 96'(drop_cnt), 96'd0);
`endif
  endtask

  int mv0;

  initial begin
    areset = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tid = '0;
    s_axis_tlast = 1'b0;
    chk_axis_tready = 1'b1;
    verdict_valid = 1'b0;
    verdict_data = 1'b0;
    m_axis_tready = 1'b1;

    // Reset values
    repeat (3) tick();
    #1;
    check_val("rst_s_tready", 96'(s_axis_tready), 96'd0);
    check_val("rst_chk_tvalid", 96'(chk_axis_tvalid), 96'd0);
    check_val("rst_m_tvalid", 96'(m_axis_tvalid), 96'd0);
    check_val("rst_v_ready", 96'(verdict_ready), 96'd0);
    s_axis_tvalid = 1'b0;
    areset = 1'b0;
    tick();
    #1;
    check_val("post_rst_s_tready", 96'(s_axis_tready), 96'd1);
    check_val("post_rst_v_ready", 96'(verdict_ready), 96'd0);
    check_counters("rst");

    // Single pass: 3 beats, tid 5, last keep 0x0F
    tick();
    send_pkt(3, 6'd5, 64'h100, 8'h0F, 3);
    give_verdict(1'b1);
    #1;
    check_val("pass_first_valid", 96'(m_axis_tvalid), 96'd1);
    check_val("pass_first_data", 96'(m_axis_tdata), 96'h100);
    wait_rx(3);
    compare_rx("pass");
    exp_pass++;
    tick();
    check_counters("pass");

    // Single fail: 2 beats, verdict 0
    mv0 = mv_cnt;
    send_pkt(2, 6'd9, 64'h200, 8'hFF, 0);
    give_verdict(1'b0);
    #1;
    check_val("drop_m_tvalid", 96'(m_axis_tvalid), 96'd0);
    tick();
    tick();
    #1;
    check_val("drop_count_empty", 96'(dut.count_q), 96'd0);
    check_val("drop_state_idle", 96'(dut.state_q), 96'd0);
    check_val("drop_no_output", 96'(mv_cnt), 96'(mv0));
    exp_drop++;
    check_counters("drop");

    // Interleaved: A pass(4), B fail(2), C pass(1)
    tick();
    send_pkt(4, 6'd1, 64'hA00, 8'h03, 4);
    give_verdict(1'b1);
    wait_rx(4);
    send_pkt(2, 6'd2, 64'hB00, 8'h07, 0);
    send_pkt(1, 6'd3, 64'hC00, 8'h01, 1);
    give_verdict(1'b0);
    give_verdict(1'b1);
    wait_rx(5);
    compare_rx("interleave");
    exp_pass += 2;
    exp_drop++;
    tick();
    check_counters("interleave");

    // Backpressure and full
    m_axis_tready = 1'b0;
    chk_toggle = 1'b1;
    send_pkt(4, 6'd4, 64'hD00, 8'h3F, 4);
    chk_toggle = 1'b0;
    chk_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'hDEAD;
    #1;
    check_val("full_s_tready", 96'(s_axis_tready), 96'd0);
    check_val("full_chk_tvalid", 96'(chk_axis_tvalid), 96'd0);
    tick();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    give_verdict(1'b1);
    #1;
    check_val("full_pop_s_tready", 96'(s_axis_tready), 96'd0);
    check_val("full_m_tvalid", 96'(m_axis_tvalid), 96'd1);
    repeat (4) tick();
    #1;
    check_val("drain_s_tready", 96'(s_axis_tready), 96'd1);
    check_val("drain_count", 96'(dut.count_q), 96'd0);
    wait_rx(4);
    compare_rx("full");
    exp_pass++;
    check_counters("full");

    // Early verdict
    tick();
    vh_cnt = 0;
    verdict_valid = 1'b1;
    verdict_data = 1'b1;
    tick();
    #1;
    check_val("early_v_ready_empty", 96'(verdict_ready), 96'd0);
    exp_q.push_back({17'd0, 1'b0, 6'd7, 8'hFF, 64'hE00});
    exp_q.push_back({17'd0, 1'b1, 6'd7, 8'h1F, 64'hE01});
    send_beat(64'hE00, 8'hFF, 6'd7, 1'b0);
    #1;
    check_val("early_v_ready_one", 96'(verdict_ready), 96'd1);
    send_beat(64'hE01, 8'h1F, 6'd7, 1'b1);
    verdict_valid = 1'b0;
    check_val("early_v_hs", 96'(vh_cnt), 96'd1);
    wait_rx(2);
    compare_rx("early");
    exp_pass++;
    tick();
    check_counters("early");

    // Reset mid-PASS
    m_axis_tready = 1'b0;
    send_pkt(4, 6'd8, 64'hF00, 8'hFF, 2);
    give_verdict(1'b1);
    m_axis_tready = 1'b1;
    tick();
    tick();
    m_axis_tready = 1'b0;
    areset = 1'b1;
    #1;
    check_val("midrst_m_tvalid", 96'(m_axis_tvalid), 96'd0);
    check_val("midrst_count", 96'(dut.count_q), 96'd0);
    check_val("midrst_state", 96'(dut.state_q), 96'd0);
    compare_rx("midrst");
    exp_pass = 0;
    exp_drop = 0;
    tick();
    areset = 1'b0;
    tick();
    #1;
    check_val("postrst_s_tready", 96'(s_axis_tready), 96'd1);
    check_val("postrst_v_ready", 96'(verdict_ready), 96'd0);
    check_counters("postrst");
    m_axis_tready = 1'b1;
    tick();
    send_pkt(1, 6'd10, 64'h1234, 8'h0F, 1);
    give_verdict(1'b1);
    wait_rx(1);
    compare_rx("fresh");
    exp_pass++;
    tick();
    check_counters("fresh");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
